// File: rtl/turn_judge.sv
// turn_judge: game-logic stage that derives c/go/win for control_unit and exports display data.
// Build option TURN_JUDGE_LOCK_EN adds a per-turn mask that rejects re-picked cards.

module turn_judge #(
  parameter int TRACK_LEN = 12,
  parameter int WIN_STEPS = 12,
  parameter int DELAY     = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  M,
  input  logic [3:0]  key,
  output logic        c,
  output logic        go,
  output logic        win,
  output logic [1:0]  cur_player,
  output logic [2:0]  nplayers,
  output logic [15:0] pos,
  output logic [2:0]  card_face
);

  // mode | meaning
  // 000  | idle, wait for a key press to start
  // 001  | player count select
  // 010  | init game state, then delay
  // 011  | pick a card
  // 100  | controller decides on go
  // 101  | miss, next player, then delay
  // 110  | advance chicken, delay unless won
  // 111  | won, everything frozen
  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_SELECT = 3'b001,
    MODE_INIT   = 3'b010,
    MODE_PICK   = 3'b011,
    MODE_DECIDE = 3'b100,
    MODE_MISS   = 3'b101,
    MODE_ADV    = 3'b110,
    MODE_WON    = 3'b111
  } mode_t;

  localparam int CW = $clog2(DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DELAY - 2);
  localparam logic [3:0]    WIN_POS  = 4'(WIN_STEPS);

  mode_t         mode;
  logic [2:0]    m_q;
  logic [3:0]    key_q;
  logic [2:0]    ring;
  logic [2:0]    shuffle;
  logic [CW-1:0] cnt;

  logic          entry;
  logic          key_rise;
  logic          counting;
  logic          pick_ok;
  logic          lock_hit;
  logic          match;
  logic [3:0]    pos_cur;
  logic [2:0]    card_idx;
  logic [2:0]    card_code;
  logic [2:0]    tile_code;
  logic [2:0]    next_player;
  int            tile;

  assign mode      = mode_t'(M);
  assign entry     = (M != m_q);
  assign key_rise  = (key != 4'd0) && (key_q == 4'd0);
  assign counting  = (mode == MODE_INIT) || (mode == MODE_MISS) || ((mode == MODE_ADV) && !win);
  assign pos_cur   = pos[4*cur_player +: 4];
  assign card_idx  = 3'(key - 4'd1);
  assign card_code = card_idx + shuffle;
  assign pick_ok   = (key != 4'd0) && (key <= 4'd8);
  assign match     = (card_code == tile_code);

  // Player p starts on tile 3p; the next step lands one tile past its progress.
  always_comb begin
    tile      = (3 * int'(cur_player) + int'(pos_cur) + 1) % TRACK_LEN;
    tile_code = 3'(tile % 8);
  end

  always_comb begin
    next_player = 3'(cur_player) + 3'd1;
    if (next_player == nplayers) next_player = 3'd0;
  end

`ifdef TURN_JUDGE_LOCK_EN
  logic [7:0] lock;
  assign lock_hit = lock[card_idx];
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q        <= '0;
      key_q      <= '0;
      ring       <= '0;
      shuffle    <= '0;
      cnt        <= '0;
      c          <= 1'b0;
      go         <= 1'b0;
      win        <= 1'b0;
      cur_player <= '0;
      nplayers   <= 3'd2;
      pos        <= '0;
      card_face  <= '0;
`ifdef TURN_JUDGE_LOCK_EN
      lock       <= '0;
`endif
    end else begin
      m_q   <= M;
      key_q <= key;
      ring  <= ring + 3'd1;
      c     <= 1'b0;
      if (mode != MODE_WON) begin
        // Pulse lands on the edge where the count reaches DELAY-1, then the count parks.
        if (entry) begin
          cnt <= '0;
        end else if (counting && (cnt != CNT_LAST)) begin
          cnt <= cnt + 1'b1;
          c   <= (cnt == CNT_PRE);
        end
        case (mode)
          MODE_IDLE: begin
            if (key_rise) begin
              c       <= 1'b1;
              shuffle <= ring;
            end
          end
          MODE_SELECT: begin
            if ((key >= 4'd2) && (key <= 4'd4)) nplayers <= key[2:0];
          end
          MODE_INIT: begin
            if (entry) begin
              pos        <= '0;
              cur_player <= '0;
              win        <= 1'b0;
              go         <= 1'b0;
`ifdef TURN_JUDGE_LOCK_EN
              lock       <= '0;
`endif
            end
          end
          MODE_PICK: begin
            if (pick_ok && !lock_hit) begin
              go        <= match;
              card_face <= card_code;
`ifdef TURN_JUDGE_LOCK_EN
              lock[card_idx] <= 1'b1;
`endif
            end else if (key != 4'd0) begin
              go <= 1'b0;
            end
          end
          MODE_MISS: begin
            if (entry) begin
              cur_player <= next_player[1:0];
`ifdef TURN_JUDGE_LOCK_EN
              lock       <= '0;
`endif
            end
          end
          MODE_ADV: begin
            if (entry && (pos_cur != WIN_POS)) begin
              pos[4*cur_player +: 4] <= pos_cur + 4'd1;
              if ((pos_cur + 4'd1) == WIN_POS) win <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_judge.sv
// Directed bench for turn_judge (DELAY = 4) with a scoreboard queue of expected values.
module tb_turn_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  M;
  logic [3:0]  key;
  logic        c, go, win;
  logic [1:0]  cur_player;
  logic [2:0]  nplayers;
  logic [15:0] pos;
  logic [2:0]  card_face;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [2:0]  tb_ring;
  logic [2:0]  sh;
  logic [2:0]  f;

  turn_judge #(.TRACK_LEN(12), .WIN_STEPS(12), .DELAY(4)) dut (
    .clk(clk), .rst(rst), .M(M), .key(key), .c(c), .go(go), .win(win),
    .cur_player(cur_player), .nplayers(nplayers), .pos(pos), .card_face(card_face)
  );

  always #5 clk = ~clk;

  // Reference for the free-running shuffle source: counts every clock since reset.
  always @(posedge clk or negedge rst)
    if (!rst) tb_ring <= 3'd0;
    else      tb_ring <= tb_ring + 3'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  task automatic push_reset_state(input string t);
    push({t, "_c"}, 0); push({t, "_go"}, 0); push({t, "_win"}, 0); push({t, "_cur"}, 0);
    push({t, "_np"}, 2); push({t, "_pos"}, 0); push({t, "_face"}, 0);
  endtask

  task automatic observe_all();
    observe(32'(c)); observe(32'(go)); observe(32'(win)); observe(32'(cur_player));
    observe(32'(nplayers)); observe(32'(pos)); observe(32'(card_face));
  endtask

  // Counts ticks from now until c is seen high; a missing pulse reports all ones.
  task automatic wait_c(input string t, input int exp_n, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    push(t, 32'(exp_n));
    while (!seen && (n < budget)) begin
      tick();
      n++;
      if (c) seen = 1;
    end
    observe(seen ? 32'(n) : 32'hFFFF_FFFF);
  endtask

  task automatic no_c(input string t, input int n);
    int hits;
    hits = 0;
    push(t, 0);
    repeat (n) begin
      tick();
      if (c) hits++;
    end
    observe(32'(hits));
  endtask

  task automatic pick(input logic [3:0] k);
    M = 3'b011; key = 4'd0; tick();
    key = k; tick();
    M = 3'b100; key = 4'd0;
  endtask

  initial begin
    rst = 1'b0; M = 3'b000; key = 4'd0;
    tick(); tick();
    push_reset_state("reset");
    observe_all();

    // Release with a key already pressed: the first edge latches shuffle = 0.
    rst = 1'b1; key = 4'd5;
    push("start_c", 1);
    tick(); observe(32'(c));
    push("start_c_1cyc", 0);
    tick(); observe(32'(c));
    key = 4'd0;

    M = 3'b001; tick();
    key = 4'd3; push("np_3", 3);
    tick(); observe(32'(nplayers));
    key = 4'd7; push("np_ignore7", 3);
    tick(); observe(32'(nplayers));
    key = 4'd0;

    M = 3'b010;
    wait_c("init_c_delay", 4, 10);
    push("init_c_drop", 0);
    tick(); observe(32'(c));

    // Player 0 at pos 0 targets tile 1; card 2 with shuffle 0 shows code 1.
    pick(4'd2);
    push("match_go", 1); push("match_face", 1);
    observe(32'(go)); observe(32'(card_face));
    tick();
    pick(4'd2);
`ifdef TURN_JUDGE_LOCK_EN
    push("repick_go", 0);
`else
    push("repick_go", 1);
`endif
    push("repick_face", 1);
    observe(32'(go)); observe(32'(card_face));
    tick();

    M = 3'b110;
    wait_c("adv_c_delay", 4, 10);
    push("adv_pos", 16'h0001); push("adv_win", 0);
    observe(32'(pos)); observe(32'(win));

    // Pos 1 targets tile 2; card 4 shows code 3.
    pick(4'd4);
    push("miss_go", 0); push("miss_face", 3);
    observe(32'(go)); observe(32'(card_face));
    tick();
    M = 3'b101;
    wait_c("miss_c_delay", 4, 10);
    push("miss_cur1", 1);
    observe(32'(cur_player));

    // Player 1 starts on tile 3, targets tile 4; card 5 shows code 4.
    pick(4'd5);
    push("p1_go", 1); push("p1_face", 4);
    observe(32'(go)); observe(32'(card_face));
    tick();
    M = 3'b101; tick();
    push("cur2", 2); observe(32'(cur_player));
    M = 3'b100; tick();
    M = 3'b101; tick();
    push("cur_wrap", 0); observe(32'(cur_player));
    M = 3'b100; tick();

    for (int i = 0; i < 10; i++) begin
      M = 3'b110; tick();
      M = 3'b100; tick();
    end
    push("pos_11", 16'h000B); observe(32'(pos));

    // Pos 11 targets tile 12 mod 12 = 0; card 1 shows code 0.
    pick(4'd1);
    push("wrap_go", 1); push("wrap_face", 0);
    observe(32'(go)); observe(32'(card_face));
    tick();
    M = 3'b110; tick();
    push("win_pos", 16'h000C); push("win_flag", 1);
    observe(32'(pos)); observe(32'(win));
    no_c("win_no_c", 8);

    M = 3'b111; key = 4'd5;
    no_c("won_no_c", 6);
    M = 3'b110; tick();
    M = 3'b111; tick();
    push("frozen_pos", 16'h000C); push("frozen_win", 1); push("frozen_cur", 0); push("frozen_go", 1);
    observe(32'(pos)); observe(32'(win)); observe(32'(cur_player)); observe(32'(go));
    key = 4'd0;

    // Reset in the middle of an advance delay.
    rst = 1'b0; tick();
    rst = 1'b1; M = 3'b000; tick();
    M = 3'b110; tick(); tick();
    push("mid_pos", 16'h0001); observe(32'(pos));
    rst = 1'b0; #1;
    push_reset_state("mid_reset");
    observe_all();
    tick();
    M = 3'b000; rst = 1'b1;
    no_c("post_reset_no_c", 8);

    // Nonzero shuffle from the running counter.
    tick(); tick();
    sh = tb_ring;
    key = 4'd7; tick();
    push("shuf_c", 1); observe(32'(c));
    key = 4'd0;
    pick(4'd3);
    f = 3'd2 + sh;
    push("shuf_face", 32'(f)); push("shuf_go", (f == 3'd1) ? 1 : 0);
    observe(32'(card_face)); observe(32'(go));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
